main_controller: RTL and testbench

Multicycle main control unit for the RV32I-subset core. It sequences every instruction through fetch, decode, execute, memory and writeback states. It drives the datapath enables and produces the 2-bit `ALUOp` that the ALU decoder expands into an ALU operation, using the encoding 00 = LW/SW add, 01 = branch compare, 10 = R/I-type, 11 = jump link. It also owns the memory request handshake, the illegal-opcode trap and a retired-instruction counter.

---
 rtl/ctrl_pkg.sv | 60 ++++++
 rtl/main_decoder.sv | 70 +++++++
 rtl/main_controller.sv | 112 +++++++++++
 tb/tb_main_controller.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle main controller.
// ALUOp codes must match the ALU decoder that expands them.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_BR   = 2'b01;
  localparam logic [1:0] ALUOP_RI   = 2'b10;
  localparam logic [1:0] ALUOP_JUMP = 2'b11;

  localparam logic [1:0] PCSRC_PLUS4 = 2'b00;
  localparam logic [1:0] PCSRC_REL   = 2'b01;
  localparam logic [1:0] PCSRC_JALR  = 2'b10;

  localparam logic [1:0] WBSEL_ALU = 2'b00;
  localparam logic [1:0] WBSEL_MEM = 2'b01;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  function automatic logic op_legal(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: op_legal = 1'b1;
      default:                                                 op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/main_decoder.sv
// Combinational control-word decode from the current state and latched opcode.
// Only FETCH/MEM look at MemReady and only branch EXEC looks at BranchCond.
module main_decoder
  import ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [6:0] opcode_q_i,
  input  logic       branch_cond_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_req  = 1'b1;
        ctrl_o.ir_write = mem_ready_i;
      end
      S_EXEC: begin
        case (opcode_q_i)
          OP_R: begin
            ctrl_o.alu_op    = ALUOP_RI;
            ctrl_o.alu_src_b = SRCB_RS2;
          end
          OP_I: begin
            ctrl_o.alu_op    = ALUOP_RI;
            ctrl_o.alu_src_b = SRCB_IMM;
          end
          OP_LOAD, OP_STORE: begin
            ctrl_o.alu_op    = ALUOP_ADD;
            ctrl_o.alu_src_b = SRCB_IMM;
          end
          OP_BRANCH: begin
            ctrl_o.alu_op    = ALUOP_BR;
            ctrl_o.alu_src_b = SRCB_RS2;
            ctrl_o.pc_write  = 1'b1;
            ctrl_o.pc_src    = branch_cond_i ? PCSRC_REL : PCSRC_PLUS4;
          end
          OP_JAL, OP_JALR: begin
            ctrl_o.alu_op    = ALUOP_JUMP;
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_FOUR;
          end
          default: ctrl_o = '0;
        endcase
      end
      S_MEM: begin
        ctrl_o.mem_req   = 1'b1;
        ctrl_o.mem_write = (opcode_q_i == OP_STORE);
        // a store retires here, so the PC advances on the completing cycle
        ctrl_o.pc_write  = (opcode_q_i == OP_STORE) && mem_ready_i;
        ctrl_o.pc_src    = PCSRC_PLUS4;
      end
      S_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.wb_sel    = (opcode_q_i == OP_LOAD) ? WBSEL_MEM : WBSEL_ALU;
        case (opcode_q_i)
          OP_JAL:  ctrl_o.pc_src = PCSRC_REL;
          OP_JALR: ctrl_o.pc_src = PCSRC_JALR;
          default: ctrl_o.pc_src = PCSRC_PLUS4;
        endcase
      end
      S_TRAP:  ctrl_o.illegal = 1'b1;
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/main_controller.sv
// Multicycle main control unit: state register, latched opcode, retire counter
// and next-state logic; the control word itself comes from main_decoder.
module main_controller
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       Opcode,
  input  logic             BranchCond,
  input  logic             MemReady,
  output logic             MemReq,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       PCSrc,
  output logic             RegWrite,
  output logic [1:0]       WBSel,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             Illegal,
  output logic [CNT_W-1:0] RetireCount,
  output logic [2:0]       State
);

  state_e           state_q, state_d;
  logic [6:0]       opcode_q, opcode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire_d;
  ctrl_t            ctrl_s;

  main_decoder u_dec (
    .state_i       (state_q),
    .opcode_q_i    (opcode_q),
    .branch_cond_i (BranchCond),
    .mem_ready_i   (MemReady),
    .ctrl_o        (ctrl_s)
  );

  // The IR is written on the FETCH completion edge, so the opcode is captured
  // on the edge leaving DECODE and classified from that same value.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    retire_d = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: state_d = MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        opcode_d = Opcode;
        state_d  = op_legal(Opcode) ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        case (opcode_q)
          OP_R, OP_I, OP_JAL, OP_JALR: state_d = S_WB;
          OP_LOAD, OP_STORE:           state_d = S_MEM;
          OP_BRANCH: begin
            state_d  = S_FETCH;
            retire_d = 1'b1;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        if (!MemReady) begin
          state_d = S_MEM;
        end else if (opcode_q == OP_STORE) begin
          state_d  = S_FETCH;
          retire_d = 1'b1;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        state_d  = S_FETCH;
        retire_d = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
    cnt_d = retire_d ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      opcode_q <= 7'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      cnt_q    <= cnt_d;
    end
  end

  assign MemReq      = ctrl_s.mem_req;
  assign MemWrite    = ctrl_s.mem_write;
  assign IRWrite     = ctrl_s.ir_write;
  assign PCWrite     = ctrl_s.pc_write;
  assign PCSrc       = ctrl_s.pc_src;
  assign RegWrite    = ctrl_s.reg_write;
  assign WBSel       = ctrl_s.wb_sel;
  assign ALUSrcA     = ctrl_s.alu_src_a;
  assign ALUSrcB     = ctrl_s.alu_src_b;
  assign ALUOp       = ctrl_s.alu_op;
  assign Illegal     = ctrl_s.illegal;
  assign RetireCount = cnt_q;
  assign State       = state_q;

endmodule

// File: tb/tb_main_controller.sv
// Directed bench: an instruction-level model expands each instruction into its
// expected per-cycle control words; one compare process checks every cycle.
module tb_main_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  Opcode;
  logic        BranchCond;
  logic        MemReady;

  logic        MemReq, MemWrite, IRWrite, PCWrite, RegWrite, ALUSrcA, Illegal;
  logic [1:0]  PCSrc, WBSel, ALUSrcB, ALUOp;
  logic [31:0] RetireCount;
  logic [2:0]  State;

  logic        w_MemReq, w_MemWrite, w_IRWrite, w_PCWrite, w_RegWrite, w_ALUSrcA, w_Illegal;
  logic [1:0]  w_PCSrc, w_WBSel, w_ALUSrcB, w_ALUOp;
  logic [1:0]  w_RetireCount;
  logic [2:0]  w_State;

  always #5 clk = ~clk;

  main_controller #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .BranchCond(BranchCond), .MemReady(MemReady),
    .MemReq(MemReq), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .RegWrite(RegWrite), .WBSel(WBSel), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .Illegal(Illegal), .RetireCount(RetireCount), .State(State)
  );

  // Narrow counter copy: wraps after 4 retirements
  main_controller #(.CNT_W(2)) dut_w (
    .clk(clk), .reset(reset), .Opcode(Opcode), .BranchCond(BranchCond), .MemReady(MemReady),
    .MemReq(w_MemReq), .MemWrite(w_MemWrite), .IRWrite(w_IRWrite), .PCWrite(w_PCWrite),
    .PCSrc(w_PCSrc), .RegWrite(w_RegWrite), .WBSel(w_WBSel), .ALUSrcA(w_ALUSrcA),
    .ALUSrcB(w_ALUSrcB), .ALUOp(w_ALUOp), .Illegal(w_Illegal), .RetireCount(w_RetireCount),
    .State(w_State)
  );

  int total = 0;
  int bad   = 0;

  logic        exp_v = 1'b0;
  logic [14:0] exp_w;
  logic [31:0] exp_cnt;
  int          model_cnt;

  function automatic logic [14:0] mk(input logic req, input logic wr, input logic irw,
                                     input logic pcw, input logic [1:0] pcs, input logic rw,
                                     input logic [1:0] wbs, input logic sa, input logic [1:0] sb,
                                     input logic [1:0] op, input logic ill);
    return {req, wr, irw, pcw, pcs, rw, wbs, sa, sb, op, ill};
  endfunction

  function automatic logic [14:0] act_word();
    return {MemReq, MemWrite, IRWrite, PCWrite, PCSrc, RegWrite, WBSel, ALUSrcA, ALUSrcB, ALUOp, Illegal};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_v) begin
      check("ctrl_word {req,wr,irw,pcw,pcsrc,rw,wbsel,srca,srcb,aluop,ill}",
            {17'd0, act_word()}, {17'd0, exp_w});
      check("retire_count", RetireCount, exp_cnt);
      check("retire_count_w2", {30'd0, w_RetireCount}, {30'd0, exp_cnt[1:0]});
    end
  end

  // One clock cycle: drive inputs, publish expectation, advance
  task automatic cyc(input logic [14:0] e, input logic mr, input logic bc, input logic ret);
    MemReady   = mr;
    BranchCond = bc;
    exp_w      = e;
    exp_cnt    = model_cnt;
    exp_v      = 1'b1;
    @(posedge clk);
    #1;
    if (ret) model_cnt++;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    model_cnt = 0;
    cyc(15'd0, 1'b1, 1'b0, 1'b0);
    cyc(15'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    cyc(15'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic instr(input logic [6:0] op, input int fw, input int mw, input logic bc);
    logic ld, st, legal;
    ld    = (op == 7'b0000011);
    st    = (op == 7'b0100011);
    legal = (op == 7'b0110011) || (op == 7'b0010011) || ld || st ||
            (op == 7'b1100011) || (op == 7'b1101111) || (op == 7'b1100111);
    Opcode = op;
    for (int i = 0; i < fw; i++)
      cyc(mk(1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0), 1'b0, bc, 1'b0);
    cyc(mk(1'b1,1'b0,1'b1,1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0), 1'b1, bc, 1'b0);
    cyc(15'd0, 1'b1, bc, 1'b0);
    if (!legal) begin
      for (int i = 0; i < 10; i++)
        cyc(mk(1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1), 1'b1, bc, 1'b0);
      return;
    end
    case (op)
      7'b0110011: cyc(mk(1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,2'b10,1'b0), 1'b1, bc, 1'b0);
      7'b0010011: cyc(mk(1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,1'b0,2'b01,2'b10,1'b0), 1'b1, bc, 1'b0);
      7'b1100011: begin
        cyc(mk(1'b0,1'b0,1'b0,1'b1,bc ? 2'b01 : 2'b00,1'b0,2'b00,1'b0,2'b00,2'b01,1'b0), 1'b1, bc, 1'b1);
        return;
      end
      7'b1101111, 7'b1100111:
        cyc(mk(1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,1'b1,2'b10,2'b11,1'b0), 1'b1, bc, 1'b0);
      default: begin
        cyc(mk(1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,1'b0,2'b01,2'b00,1'b0), 1'b1, bc, 1'b0);
        for (int i = 0; i < mw; i++)
          cyc(mk(1'b1,st,1'b0,1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0), 1'b0, bc, 1'b0);
        cyc(mk(1'b1,st,1'b0,st,2'b00,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0), 1'b1, bc, st);
        if (st) return;
      end
    endcase
    cyc(mk(1'b0,1'b0,1'b0,1'b1,
           (op == 7'b1101111) ? 2'b01 : (op == 7'b1100111) ? 2'b10 : 2'b00,
           1'b1, ld ? 2'b01 : 2'b00, 1'b0,2'b00,2'b00,1'b0), 1'b1, bc, 1'b1);
  endtask

  initial begin
    reset      = 1'b1;
    Opcode     = 7'd0;
    BranchCond = 1'b0;
    MemReady   = 1'b0;
    model_cnt  = 0;
    @(posedge clk);
    #1;
    do_reset();

    instr(7'b0110011, 0, 0, 1'b0);
    check("r_retired_lit", RetireCount, 32'd1);
    instr(7'b0010011, 1, 0, 1'b1);
    instr(7'b0000011, 0, 2, 1'b0);
    instr(7'b0100011, 0, 1, 1'b0);
    check("four_retired_lit", RetireCount, 32'd4);
    check("w2_wrapped_lit", {30'd0, w_RetireCount}, 32'd0);
    instr(7'b0100011, 2, 0, 1'b1);
    instr(7'b1100011, 0, 0, 1'b1);
    instr(7'b1100011, 0, 0, 1'b0);
    instr(7'b1101111, 0, 0, 1'b0);
    instr(7'b1100111, 1, 0, 1'b1);
    check("nine_retired_lit", RetireCount, 32'd9);

    // Reset in the middle of a pending fetch
    Opcode = 7'b0110011;
    cyc(mk(1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0), 1'b0, 1'b0, 1'b0);
    exp_v = 1'b0;
    #1;
    check("memreq_pending_lit", {31'd0, MemReq}, 32'd1);
    reset = 1'b1;
    #1;
    check("memreq_drop_lit", {31'd0, MemReq}, 32'd0);
    check("no_wen_lit", {30'd0, PCWrite, RegWrite}, 32'd0);
    check("cnt_cleared_lit", RetireCount, 32'd0);
    @(posedge clk);
    #1;
    do_reset();

    instr(7'b1111111, 0, 0, 1'b0);
    check("illegal_lit", {31'd0, Illegal}, 32'd1);
    do_reset();
    instr(7'b0110011, 0, 0, 1'b0);
    check("after_trap_lit", RetireCount, 32'd1);

    exp_v = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
